// File: rtl/lt24_touch_adc_responder.sv
// LT24 touch ADC responder: ADS7843-style SPI slave fed from supplied X/Y/touch values.
// Ports: clk, reset (async high), spi_cs_n/spi_dclk/spi_din -> spi_dout/busy,
//   pen_irq_n out, touch/x_pos/y_pos in, aux_in3/aux_in4 only with LT24_TOUCH_AUX_CH_EN.
module lt24_touch_adc_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] Z1_TOUCHED  = 12'h200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic        spi_dclk,
  input  logic        spi_din,
  output logic        spi_dout,
  output logic        busy,
  output logic        pen_irq_n,
  input  logic        touch,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos
`ifdef LT24_TOUCH_AUX_CH_EN
  ,
  input  logic [11:0] aux_in3,
  input  logic [11:0] aux_in4
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_BWAIT,
    S_BUSY,
    S_DATA
  } state_t;

  logic [SYNC_STAGES-1:0] dclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic [SYNC_STAGES-1:0] touch_sync_q;
  logic                   dclk_prev_q;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  cmd_q, cmd_d;
  logic [11:0] sh_q, sh_d;
  logic        mode_q, mode_d;
  logic        ser_unused_q, ser_d;
  logic [1:0]  pd_q, pd_d;
  logic        busy_q, busy_d;
  logic        dout_q, dout_d;
  logic        pen_q, pen_d;

  logic        dclk_s, cs_s, din_s, touch_s;
  logic        rise, fall;
  logic [3:0]  last_cnt;
  logic [11:0] sel_res;

  assign dclk_s  = dclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign din_s   = din_sync_q[SYNC_STAGES-1];
  assign touch_s = touch_sync_q[SYNC_STAGES-1];

  // DCLK edges only count while the chip is selected
  assign rise = dclk_s & ~dclk_prev_q & ~cs_s;
  assign fall = ~dclk_s & dclk_prev_q & ~cs_s;

  assign last_cnt = mode_q ? 4'd8 : 4'd12;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      din_sync_q   <= '0;
      touch_sync_q <= '0;
      dclk_prev_q  <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      cmd_q        <= 7'd0;
      sh_q         <= 12'd0;
      mode_q       <= 1'b0;
      ser_unused_q <= 1'b0;
      pd_q         <= 2'b00;
      busy_q       <= 1'b0;
      dout_q       <= 1'b0;
      pen_q        <= 1'b1;
    end else begin
      dclk_sync_q  <= {dclk_sync_q[SYNC_STAGES-2:0], spi_dclk};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      din_sync_q   <= {din_sync_q[SYNC_STAGES-2:0], spi_din};
      touch_sync_q <= {touch_sync_q[SYNC_STAGES-2:0], touch};
      dclk_prev_q  <= dclk_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      sh_q         <= sh_d;
      mode_q       <= mode_d;
      ser_unused_q <= ser_d;
      pd_q         <= pd_d;
      busy_q       <= busy_d;
      dout_q       <= dout_d;
      pen_q        <= pen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_CMD;
        S_CMD:   if (rise && cnt_q == 4'd7) state_d = S_BWAIT;
        S_BWAIT: if (fall) state_d = S_BUSY;
        S_BUSY:  if (fall) state_d = S_DATA;
        S_DATA:  if (fall && cnt_q == last_cnt) state_d = S_CMD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_res = 12'd0;
    unique case (cmd_q[6:4])
      3'b101:  sel_res = touch_s ? x_pos : 12'd0;
      3'b001:  sel_res = touch_s ? y_pos : 12'd0;
      3'b011:  sel_res = touch_s ? Z1_TOUCHED : 12'd0;
`ifdef LT24_TOUCH_AUX_CH_EN
      3'b010:  sel_res = aux_in3;
      3'b110:  sel_res = aux_in4;
`endif
      default: sel_res = 12'd0;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    cmd_d  = cmd_q;
    sh_d   = sh_q;
    mode_d = mode_q;
    ser_d  = ser_unused_q;
    pd_d   = pd_q;
    busy_d = busy_q;
    dout_d = dout_q;
    if (cs_s) begin
      cnt_d  = 4'd0;
      busy_d = 1'b0;
      dout_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: cnt_d = 4'd0;
        S_CMD: begin
          // cnt_q==0 means still hunting for the start bit
          if (rise) begin
            if (cnt_q == 4'd0) begin
              if (din_s) cnt_d = 4'd1;
            end else begin
              cmd_d = {cmd_q[5:0], din_s};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        S_BWAIT: begin
          if (fall) begin
            busy_d = 1'b1;
            sh_d   = sel_res;
            mode_d = cmd_q[3];
            ser_d  = cmd_q[2];
            pd_d   = cmd_q[1:0];
          end
        end
        S_BUSY: begin
          if (fall) begin
            busy_d = 1'b0;
            dout_d = sh_q[11];
            sh_d   = {sh_q[10:0], 1'b0};
            cnt_d  = 4'd1;
          end
        end
        S_DATA: begin
          if (fall) begin
            if (cnt_q == last_cnt) begin
              dout_d = 1'b0;
              cnt_d  = 4'd0;
            end else begin
              dout_d = sh_q[11];
              sh_d   = {sh_q[10:0], 1'b0};
              cnt_d  = cnt_q + 4'd1;
            end
          end
        end
        default: cnt_d = 4'd0;
      endcase
    end
  end

  // Pen IRQ only reflects the panel while no command is in flight
  always_comb begin
    pen_d = 1'b1;
    if (state_d == S_IDLE || (state_d == S_CMD && cnt_d == 4'd0))
      pen_d = ~(touch_s & ~pd_d[0]);
  end

  assign spi_dout  = dout_q;
  assign busy      = busy_q;
  assign pen_irq_n = pen_q;

endmodule
